flux_encoder_multimode: RTL
===========================

# flux_encoder_multimode

Parametrised serial flux-cell encoder: successor to the single-mode M2FM serial encoder, supporting FM, MFM and true M2FM (previous-clock suppression) selectable per word. A small input FIFO accepts data bytes and raw 16-bit mark words. The encoder serialises them MSB-first on the DPLL cell strobe, with gap-fill on underrun. It sits between the write-path format sequencer and the write precompensation / flux output stage.

## Interface
- FIFO_DEPTH, 4: FIFO entries; power of 2, ≥2. AW = log2(FIFO_DEPTH).
- FILL_BYTE, 8'h4E: byte encoded when the FIFO is empty while transmitting.
- clk  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- enable  in  1  global advance; when low, all state holds and pulses are 0.
- bit_clk  in  1  cell strobe, one clk wide, 2× data rate.
- mode  in  2  00 FM, 01 MFM, 10 M2FM, 11 reserved (treated as FM); sampled at word load only.
- tx_en  in  1  transmit request.
- wr_data  in  16  raw word, or byte in [7:0] ([15:8] ignored).
- wr_raw  in  1  1 = wr_data is a raw cell pattern emitted verbatim.
- wr_valid  in  1  write strobe.
- wr_ready  out  1  = !full (combinational).
- flux_out  out  1  current cell value.
- flux_valid  out  1  one-cycle pulse per emitted cell.
- byte_complete  out  1  pulse on the 16th cell of each word.
- busy  out  1  state == SHIFT.
- underrun  out  1  sticky; set when a fill word is loaded.
- fifo_level  out  AW+1  occupied entries.

## Operation
- FIFO entry is 17 bits {raw, data16}. Write is accepted iff wr_valid && !full in that cycle. A write while full is dropped, even if a read occurs in the same cycle. There is no empty bypass: a written entry is readable the cycle after.
- Encoder state: prev_data, prev_clock (reset 0). A word is encoded fully at load into a 16-bit shift register, cells ordered clock,data per bit, MSB first.
- Per data bit d, MSB→LSB:
  - FM: c = 1.
  - MFM: c = ~pd & ~d.
  - M2FM: c = ~pd & ~d & ~pc.
  - Then pd = d, pc = c.
- Raw word: loaded verbatim; pd ← word[0], pc ← word[1].
- After every load, prev_data/prev_clock hold the last data/clock cell of the loaded word.
- FSM IDLE/SHIFT:
  - IDLE: if tx_en && FIFO non-empty → pop, load, cell_cnt = 0, → SHIFT. Does not wait for bit_clk.
  - SHIFT, on bit_clk: flux_out ← sreg[15], flux_valid = 1, shift left, cell_cnt++.
  - SHIFT, cell_cnt == 15 on bit_clk: byte_complete = 1 and next-word decision in the same cycle:
    - FIFO non-empty → pop/load.
    - else tx_en → load FILL_BYTE encoded, underrun ← 1.
    - else → IDLE.
- tx_en falling mid-word: the current word completes, then IDLE. underrun clears when IDLE && !tx_en.
- prev state persists across IDLE (the next word chains correctly); reset returns it to 0.

## Timing
- Reset values: flux_out 0, flux_valid 0, byte_complete 0, busy 0, underrun 0, fifo_level 0, wr_ready 1. FIFO pointers, cell_cnt and prev state are all 0. The FSM is in IDLE.
- Reset mid-word: the word is abandoned, the FIFO is flushed, and no further pulses occur.
- Write → earliest load: 2 clk (write, then IDLE load). Load → first cell: next bit_clk.
- Word-to-word: gapless. The 16th cell of word N and the load of N+1 share one bit_clk; the first cell of N+1 comes on the next bit_clk.
- bit_clk with enable low is ignored (not deferred).

## Configuration
- FLUXENC_M2FM_EN defined: mode 10 uses the M2FM rule above.
- Not defined: M2FM rule logic and prev_clock tracking are removed, and mode 10 encodes as MFM. Raw words still emit verbatim.

## Test plan
- MFM, reset prev: bytes 0x00, 0xFF → cells 0xAAAA then 0x5555, 32 flux_valid pulses, 2 byte_complete, no gap between the words.
- FM: 0x00, 0xFF → 0xAAAA, 0xFFFF.
- M2FM (macro on), reset prev: 0x00 → 0x8888. With macro off: 0xAAAA.
- M2FM: raw 0xF77A then byte 0x00 → 0xF77A verbatim, then 0x2222 (pc = 1 suppresses the first clock).
- MFM, tx_en held: single byte 0x00, FIFO runs dry → next word is FILL_BYTE 0x4E encoded (0x9254 with pd = 0), underrun = 1. Drop tx_en → IDLE after that word, underrun clears.
- FIFO_DEPTH 4, tx_en low: 5 writes → fifo_level 4, wr_ready 0, 5th dropped. Assert reset mid-word after tx_en → all outputs at reset values next cycle.

Source files
------------

// File: rtl/flux_encoder_multimode.sv
// -----------------------------------------------------------------------------
// flux_encoder_multimode
//
// Serial flux-cell encoder for the write path. Data bytes and raw 16-bit mark
// words enter a small FIFO. Each word is encoded in full when it is loaded
// into a 16-bit shift register. Cells are ordered clock,data per data bit,
// MSB first, and leave one per DPLL cell strobe. When the FIFO runs dry while
// transmit is still requested, FILL_BYTE is encoded as gap fill and the sticky
// underrun flag is set.
//
// Encoding rules, selected per word by mode at load time:
//   00 FM   : clock = 1
//   01 MFM  : clock = ~prev_data & ~data
//   10 M2FM : clock = ~prev_data & ~data & ~prev_clock   (FLUXENC_M2FM_EN)
//   11      : treated as FM
// Raw words are emitted verbatim. After a raw word, prev_data = word[0] and
// prev_clock = word[1].
//
// Build option:
//   FLUXENC_M2FM_EN defined   : mode 10 uses the M2FM rule with prev_clock.
//   FLUXENC_M2FM_EN undefined : prev_clock is not tracked, and mode 10
//                               encodes as MFM.
//
// Ports:
//   clk            in   system clock (single domain)
//   reset          in   synchronous, active-high
//   enable         in   global advance; when low the encoder holds
//   bit_clk        in   cell strobe, one clk wide
//   mode[1:0]      in   encoding mode, sampled at word load
//   tx_en          in   transmit request
//   wr_data[15:0]  in   raw word, or byte in [7:0]
//   wr_raw         in   1 = wr_data is a raw cell pattern
//   wr_valid       in   FIFO write strobe
//   wr_ready       out  FIFO not full
//   flux_out       out  current cell value
//   flux_valid     out  one-cycle pulse per emitted cell
//   byte_complete  out  pulse with the 16th cell of each word
//   busy           out  encoder is shifting a word
//   underrun       out  sticky; a fill word was loaded
//   fifo_level     out  occupied FIFO entries
// -----------------------------------------------------------------------------
module flux_encoder_multimode #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  FILL_BYTE  = 8'h4E,
  localparam int         AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          bit_clk,
  input  logic [1:0]    mode,
  input  logic          tx_en,
  input  logic [15:0]   wr_data,
  input  logic          wr_raw,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          flux_out,
  output logic          flux_valid,
  output logic          byte_complete,
  output logic          busy,
  output logic          underrun,
  output logic [AW:0]   fifo_level
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;

  // FIFO: entry = {raw, data16}
  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [AW:0]   level;
  logic          full, empty, wr_en;
  logic [16:0]   head;

  // Encoder / serialiser
  logic [15:0]   sreg_q;
  logic [3:0]    cell_cnt_q;
  logic          prev_data_q;
  logic          underrun_q;
  logic          flux_out_q, flux_valid_q, byte_complete_q;

  logic          pop, load, use_fill, shift, last;
  logic [16:0]   load_entry;
  logic [15:0]   enc_cells;
  logic          enc_pd;

`ifdef FLUXENC_M2FM_EN
  logic          prev_clock_q;
  logic          enc_pc;
  logic [17:0]   enc;

  // Returns {cells[15:0], last_data, last_clock}.
  function automatic logic [17:0] encode_word(input logic [16:0] entry,
                                              input logic [1:0]  md,
                                              input logic        pd,
                                              input logic        pc);
    logic [15:0] cells;
    logic        d, c, p_d, p_c;
    cells = '0;
    p_d   = pd;
    p_c   = pc;
    c     = 1'b0;
    if (entry[16]) begin
      cells = entry[15:0];
      p_d   = entry[0];
      p_c   = entry[1];
    end else begin
      for (int i = 7; i >= 0; i--) begin
        d = entry[i];
        case (md)
          2'b01:   c = ~p_d & ~d;
          2'b10:   c = ~p_d & ~d & ~p_c;
          default: c = 1'b1;
        endcase
        cells[2*i+1] = c;
        cells[2*i]   = d;
        p_d = d;
        p_c = c;
      end
    end
    return {cells, p_d, p_c};
  endfunction

  assign enc       = encode_word(load_entry, mode, prev_data_q, prev_clock_q);
  assign enc_cells = enc[17:2];
  assign enc_pd    = enc[1];
  assign enc_pc    = enc[0];
`else
  logic [16:0]   enc;

  // Returns {cells[15:0], last_data}. Mode 10 falls back to MFM.
  function automatic logic [16:0] encode_word(input logic [16:0] entry,
                                              input logic [1:0]  md,
                                              input logic        pd);
    logic [15:0] cells;
    logic        d, c, p_d;
    cells = '0;
    p_d   = pd;
    c     = 1'b0;
    if (entry[16]) begin
      cells = entry[15:0];
      p_d   = entry[0];
    end else begin
      for (int i = 7; i >= 0; i--) begin
        d = entry[i];
        case (md)
          2'b01, 2'b10: c = ~p_d & ~d;
          default:      c = 1'b1;
        endcase
        cells[2*i+1] = c;
        cells[2*i]   = d;
        p_d = d;
      end
    end
    return {cells, p_d};
  endfunction

  assign enc       = encode_word(load_entry, mode, prev_data_q);
  assign enc_cells = enc[16:1];
  assign enc_pd    = enc[0];
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign level      = wptr_q - rptr_q;
  assign full       = (level == (AW+1)'(FIFO_DEPTH));
  assign empty      = (level == '0);
  // A write while full is dropped even if a pop frees a slot this cycle.
  // Writes do not depend on enable, so the producer is never stalled by it.
  assign wr_en      = wr_valid && !full;
  assign head       = mem_q[rptr_q[AW-1:0]];
  assign wr_ready   = !full;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= {wr_raw, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign load_entry = use_fill ? {1'b0, 8'h00, FILL_BYTE} : head;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load     = 1'b0;
    use_fill = 1'b0;
    shift    = 1'b0;
    last     = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          // The first load does not wait for a cell strobe.
          if (tx_en && !empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_clk) begin
            shift = 1'b1;
            if (cell_cnt_q == 4'd15) begin
              // Last cell and next-word load share this strobe: gapless.
              last = 1'b1;
              if (!empty) begin
                pop  = 1'b1;
                load = 1'b1;
              end else if (tx_en) begin
                load     = 1'b1;
                use_fill = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cell_cnt_q      <= '0;
      prev_data_q     <= 1'b0;
      underrun_q      <= 1'b0;
      flux_out_q      <= 1'b0;
      flux_valid_q    <= 1'b0;
      byte_complete_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flux_valid_q    <= shift;
      byte_complete_q <= last;
      if (shift) flux_out_q <= sreg_q[15];
      if (load) begin
        cell_cnt_q  <= '0;
        prev_data_q <= enc_pd;
      end else if (shift) begin
        cell_cnt_q  <= cell_cnt_q + 4'd1;
      end
      if (use_fill) begin
        underrun_q <= 1'b1;
      end else if (enable && state_q == IDLE && !tx_en) begin
        underrun_q <= 1'b0;
      end
    end
  end

`ifdef FLUXENC_M2FM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_clock_q <= 1'b0;
    end else if (load) begin
      prev_clock_q <= enc_pc;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Shift register (datapath, not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load) begin
      sreg_q <= enc_cells;
    end else if (shift) begin
      sreg_q <= {sreg_q[14:0], 1'b0};
    end
  end

  assign flux_out      = flux_out_q;
  assign flux_valid    = flux_valid_q;
  assign byte_complete = byte_complete_q;
  assign busy          = (state_q == SHIFT);
  assign underrun      = underrun_q;

endmodule
